grid_writer: RTL and testbench
==============================

GRID_WRITER -- requirements
Module: grid_writer

Interface
REQ-001 SHALL have parameter GRID_COLS, default 40, cells per row.
REQ-002 SHALL have parameter GRID_ROWS, default 30, rows per grid.
REQ-003 SHALL have port clk_74a, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1, command present.
REQ-006 SHALL have port cmd_ready, output, 1, block can accept a command this cycle.
REQ-007 SHALL have port cmd_op, input, 3, opcode: 0 NOP, 1 SET, 2 CLEAR, 3 TOGGLE, 4 CLEAR_ALL, 5 FILL_ALL, 6 FILL_ROW, 7 INVERT_ALL.
REQ-008 SHALL have port cmd_col, input, 6, target column.
REQ-009 SHALL have port cmd_row, input, 5, target row.
REQ-010 SHALL have port grid_ram, output, [0:GRID_ROWS*GRID_COLS-1], registered cell bitmap; cell (col,row) is bit row*GRID_COLS+col; 1 = lit.
REQ-011 SHALL have port busy, output, 1, multi-cycle sweep in progress.
REQ-012 SHALL have port cmd_error, output, 1, one-cycle pulse on a rejected command.

Function
REQ-013 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; cmd_op/cmd_col/cmd_row are sampled on that edge only.
REQ-014 FSM states SHALL be IDLE and SWEEP; cmd_ready SHALL equal 1 in IDLE and 0 in SWEEP.
REQ-015 SET/CLEAR/TOGGLE SHALL update the addressed bit on the accepting edge: visible on grid_ram the next cycle; state stays IDLE.
REQ-016 FILL_ROW SHALL set all GRID_COLS bits of cmd_row on the accepting edge; cmd_col ignored.
REQ-017 NOP SHALL be accepted with no grid change and no error.
REQ-018 Cell ops with cmd_col>=GRID_COLS or cmd_row>=GRID_ROWS, and FILL_ROW with cmd_row>=GRID_ROWS, SHALL leave grid_ram unchanged and pulse cmd_error for exactly the cycle after acceptance.
REQ-019 CLEAR_ALL/FILL_ALL/INVERT_ALL SHALL enter SWEEP on acceptance, latch the opcode, and reset a row counter to 0.
REQ-020 In SWEEP, each cycle SHALL apply the latched op to one full row (row counter value), then increment the counter: row 0 on the first SWEEP cycle, row GRID_ROWS-1 on cycle GRID_ROWS.
REQ-021 After processing row GRID_ROWS-1 the FSM SHALL return to IDLE; cmd_ready is 1 again GRID_ROWS+1 cycles after the accepting edge.
REQ-022 busy SHALL be 1 exactly while in SWEEP.
REQ-023 cmd_valid asserted during SWEEP SHALL be ignored (not accepted) and SHALL NOT alter the sweep.
REQ-024 Row counter SHALL be 5 bits and SHALL NOT wrap past GRID_ROWS-1.
REQ-025 grid_ram SHALL change only per REQ-015/016/020; no combinational path from inputs to grid_ram.

Reset
REQ-026 On reset assertion, asynchronously: grid_ram all 0, state IDLE, row counter 0, busy 0, cmd_error 0, cmd_ready 1.
REQ-027 Reset mid-SWEEP SHALL abort the sweep; partially processed rows are cleared with the rest of grid_ram.
REQ-028 No command SHALL be accepted while reset is asserted.

Structure
REQ-029 GRID_COLS, GRID_ROWS, total-cell constant and the opcode encodings SHALL live in a shared package, used by this block and the pixel reader.
REQ-030 A sub-module grid_row_op SHALL compute one new row from (old row, op, column, column-valid); used for both single-cell and sweep paths.

Verification
REQ-031 Reset, then SET (5,3) -> bit 125 =1 next cycle, all other bits 0, cmd_error 0.
REQ-032 TOGGLE (39,29) twice on back-to-back cycles -> bit 1199 goes 1 then 0; cmd_ready stays 1.
REQ-033 SET (40,0) and FILL_ROW row 30 -> grid unchanged, cmd_error one-cycle pulse each.
REQ-034 FILL_ALL held with cmd_valid=1 continuously -> busy 1 for 30 cycles, row r lit after SWEEP cycle r+1, all 1200 bits =1, cmd_ready returns 1 on cycle 31, no second sweep started during busy.
REQ-035 FILL_ROW row 2, then INVERT_ALL -> row 2 bits 80..119 =0, all others =1 after sweep.
REQ-036 FILL_ALL, assert reset at SWEEP cycle 12 -> grid_ram immediately all 0, busy 0, cmd_ready 1 after release.

Source files
------------

// File: rtl/grid_writer_pkg.sv
// Shared grid geometry and command opcodes for the grid writer and the pixel reader.
// The geometry constants also serve as the default parameter values of the blocks that use them.
package grid_writer_pkg;

  localparam int unsigned GRID_COLS  = 40;
  localparam int unsigned GRID_ROWS  = 30;
  localparam int unsigned GRID_CELLS = GRID_COLS * GRID_ROWS;

  typedef enum logic [2:0] {
    OpNop       = 3'd0,
    OpSet       = 3'd1,
    OpClear     = 3'd2,
    OpToggle    = 3'd3,
    OpClearAll  = 3'd4,
    OpFillAll   = 3'd5,
    OpFillRow   = 3'd6,
    OpInvertAll = 3'd7
  } grid_op_e;

  function automatic logic is_sweep_op(grid_op_e op);
    return (op == OpClearAll) || (op == OpFillAll) || (op == OpInvertAll);
  endfunction

endpackage

// File: rtl/grid_row_op.sv
// Computes the next value of one grid row from its current value and an opcode.
// Cell ops only touch the column selected by col, and only when col_valid is set.
module grid_row_op
  import grid_writer_pkg::*;
#(
  parameter int unsigned COLS = GRID_COLS
) (
  input  logic [COLS-1:0] old_row,
  input  logic [2:0]      op,
  input  logic [5:0]      col,
  input  logic            col_valid,
  output logic [COLS-1:0] new_row
);

  logic [COLS-1:0] cell_mask;

  always_comb begin
    cell_mask = '0;
    for (int unsigned i = 0; i < COLS; i++) begin
      cell_mask[i] = col_valid && (32'(col) == i);
    end
  end

  always_comb begin
    new_row = old_row;
    unique case (grid_op_e'(op))
      OpSet:                 new_row = old_row | cell_mask;
      OpClear:               new_row = old_row & ~cell_mask;
      OpToggle:              new_row = old_row ^ cell_mask;
      OpFillRow, OpFillAll:  new_row = '1;
      OpClearAll:            new_row = '0;
      OpInvertAll:           new_row = ~old_row;
      default:               new_row = old_row;
    endcase
  end

endmodule

// File: rtl/grid_writer.sv
// Command-driven writer for a cell bitmap: single-cell and single-row ops finish in one cycle,
// whole-grid ops sweep one row per cycle while the block reports busy.
module grid_writer #(
  parameter int unsigned GRID_COLS = grid_writer_pkg::GRID_COLS,
  parameter int unsigned GRID_ROWS = grid_writer_pkg::GRID_ROWS
) (
  input  logic                             clk_74a,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [2:0]                       cmd_op,
  input  logic [5:0]                       cmd_col,
  input  logic [4:0]                       cmd_row,
  output logic [0:GRID_ROWS*GRID_COLS-1]   grid_ram,
  output logic                             busy,
  output logic                             cmd_error
);

  import grid_writer_pkg::*;

  typedef enum logic {StIdle, StSweep} state_e;

  state_e                 state_q, state_d;
  grid_op_e               op_q, op_d;
  logic [4:0]             row_cnt_q, row_cnt_d;
  logic                   err_q, err_d;
  logic [GRID_COLS-1:0]   rows_q [GRID_ROWS];

  logic                   row_ok, col_ok;
  logic                   row_we;
  logic [4:0]             sel_row;
  logic [2:0]             ro_op;
  logic                   ro_col_valid;
  logic [GRID_COLS-1:0]   old_row, new_row;

  assign row_ok    = 32'(cmd_row) < GRID_ROWS;
  assign col_ok    = 32'(cmd_col) < GRID_COLS;
  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q == StSweep);
  assign cmd_error = err_q;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    row_cnt_d    = row_cnt_q;
    err_d        = 1'b0;
    row_we       = 1'b0;
    sel_row      = row_ok ? cmd_row : 5'd0;
    ro_op        = cmd_op;
    ro_col_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          unique case (grid_op_e'(cmd_op))
            OpSet, OpClear, OpToggle: begin
              if (row_ok && col_ok) begin
                row_we       = 1'b1;
                ro_col_valid = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            OpFillRow: begin
              if (row_ok) row_we = 1'b1;
              else        err_d  = 1'b1;
            end
            OpClearAll, OpFillAll, OpInvertAll: begin
              state_d   = StSweep;
              op_d      = grid_op_e'(cmd_op);
              row_cnt_d = 5'd0;
            end
            default: ;
          endcase
        end
      end
      StSweep: begin
        sel_row = row_cnt_q;
        ro_op   = op_q;
        row_we  = 1'b1;
        // Counter parks on the last row instead of wrapping.
        if (row_cnt_q == 5'(GRID_ROWS - 1)) state_d = StIdle;
        else                                 row_cnt_d = row_cnt_q + 5'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign old_row = rows_q[sel_row];

  grid_row_op #(
    .COLS(GRID_COLS)
  ) u_row_op (
    .old_row   (old_row),
    .op        (ro_op),
    .col       (cmd_col),
    .col_valid (ro_col_valid),
    .new_row   (new_row)
  );

  always_ff @(posedge clk_74a or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= OpNop;
      row_cnt_q <= 5'd0;
      err_q     <= 1'b0;
      for (int r = 0; r < int'(GRID_ROWS); r++) rows_q[r] <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      row_cnt_q <= row_cnt_d;
      err_q     <= err_d;
      if (row_we) rows_q[sel_row] <= new_row;
    end
  end

  always_comb begin
    grid_ram = '0;
    for (int r = 0; r < int'(GRID_ROWS); r++) begin
      for (int c = 0; c < int'(GRID_COLS); c++) begin
        grid_ram[r * int'(GRID_COLS) + c] = rows_q[r][c];
      end
    end
  end

endmodule

// File: tb/tb_grid_writer.sv
// Self-checking bench for grid_writer: vector table, directed sweep/reset sequences,
// and random commands against a cell-array reference model.
module tb_grid_writer;

  localparam int COLS  = 40;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic             clk_74a = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [5:0]       cmd_col;
  logic [4:0]       cmd_row;
  logic [0:CELLS-1] grid_ram;
  logic             busy;
  logic             cmd_error;

  grid_writer #(
    .GRID_COLS(COLS),
    .GRID_ROWS(ROWS)
  ) dut (
    .clk_74a   (clk_74a),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_col   (cmd_col),
    .cmd_row   (cmd_row),
    .grid_ram  (grid_ram),
    .busy      (busy),
    .cmd_error (cmd_error)
  );

  always #5 clk_74a = ~clk_74a;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain cell array plus "sweep cycles still to run".
  bit exp_grid [CELLS];
  int sweep_left;
  int sweep_op;
  bit exp_err;

  typedef struct {
    logic [2:0] op;
    int         col;
    int         row;
    logic       exp_err;
    int         probe;
    logic       probe_val;
  } vec_t;

  vec_t vecs [12];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_grid(string name);
    int first = -1;
    for (int i = 0; i < CELLS; i++) begin
      if (grid_ram[i] !== exp_grid[i]) begin
        first = i;
        break;
      end
    end
    n_checks++;
    if (first >= 0) begin
      n_fail++;
      $display("FAIL %s at %0t: bit %0d got %0b expected %0b", name, $time, first,
               grid_ram[first], exp_grid[first]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CELLS; i++) exp_grid[i] = 1'b0;
    sweep_left = 0;
    sweep_op   = 0;
    exp_err    = 1'b0;
  endtask

  task automatic model_edge(logic v, int op, int col, int row);
    exp_err = 1'b0;
    if (sweep_left > 0) begin
      int r = ROWS - sweep_left;
      for (int c = 0; c < COLS; c++) begin
        if (sweep_op == 4)      exp_grid[r*COLS + c] = 1'b0;
        else if (sweep_op == 5) exp_grid[r*COLS + c] = 1'b1;
        else                    exp_grid[r*COLS + c] = ~exp_grid[r*COLS + c];
      end
      sweep_left--;
    end else if (v) begin
      if (op >= 1 && op <= 3) begin
        if (col < COLS && row < ROWS) begin
          if (op == 1)      exp_grid[row*COLS + col] = 1'b1;
          else if (op == 2) exp_grid[row*COLS + col] = 1'b0;
          else              exp_grid[row*COLS + col] = ~exp_grid[row*COLS + col];
        end else begin
          exp_err = 1'b1;
        end
      end else if (op == 6) begin
        if (row < ROWS) for (int c = 0; c < COLS; c++) exp_grid[row*COLS + c] = 1'b1;
        else exp_err = 1'b1;
      end else if (op == 4 || op == 5 || op == 7) begin
        sweep_left = ROWS;
        sweep_op   = op;
      end
    end
  endtask

  // One clock: drive, clock, advance the model, sample 1 time unit after the edge.
  task automatic cycle(logic v, logic [2:0] op, int col, int row);
    cmd_valid = v;
    cmd_op    = op;
    cmd_col   = col[5:0];
    cmd_row   = row[4:0];
    @(posedge clk_74a);
    model_edge(v, int'(op), col, row);
    #1;
    check_grid("grid");
    check("busy", 32'(busy), 32'(sweep_left > 0));
    check("cmd_ready", 32'(cmd_ready), 32'(sweep_left == 0));
    check("cmd_error", 32'(cmd_error), 32'(exp_err));
  endtask

  task automatic do_reset();
    // A valid SET held during reset must not be accepted.
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_col   = 6'd0;
    cmd_row   = 5'd0;
    reset     = 1'b1;
    repeat (2) @(posedge clk_74a);
    #1;
    check("reset_grid_any", 32'(|grid_ram), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(cmd_ready), 32'd1);
    check("reset_err", 32'(cmd_error), 32'd0);
    cmd_valid = 1'b0;
    reset     = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int busy_cnt;
    int bad;

    vecs[0]  = '{3'd1,  5,  3, 1'b0,  125, 1'b1};
    vecs[1]  = '{3'd3, 39, 29, 1'b0, 1199, 1'b1};
    vecs[2]  = '{3'd3, 39, 29, 1'b0, 1199, 1'b0};
    vecs[3]  = '{3'd1, 40,  0, 1'b1,   40, 1'b0};
    vecs[4]  = '{3'd6,  7, 30, 1'b1, 1199, 1'b0};
    vecs[5]  = '{3'd0,  0,  0, 1'b0,  125, 1'b1};
    vecs[6]  = '{3'd2,  5,  3, 1'b0,  125, 1'b0};
    vecs[7]  = '{3'd6, 63,  1, 1'b0,   79, 1'b1};
    vecs[8]  = '{3'd1,  0, 31, 1'b1,    0, 1'b0};
    vecs[9]  = '{3'd2, 10,  1, 1'b0,   50, 1'b0};
    vecs[10] = '{3'd3, 63,  0, 1'b1,   39, 1'b0};
    vecs[11] = '{3'd1, 39,  0, 1'b0,   39, 1'b1};

    model_reset();
    do_reset();

    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, vecs[i].op, vecs[i].col, vecs[i].row);
      check("vec_err", 32'(cmd_error), 32'(vecs[i].exp_err));
      check("vec_probe", 32'(grid_ram[vecs[i].probe]), 32'(vecs[i].probe_val));
    end
    cycle(1'b0, 3'd0, 0, 0);
    check("err_drops", 32'(cmd_error), 32'd0);

    // FILL_ALL with cmd_valid held high throughout the sweep.
    do_reset();
    busy_cnt = 0;
    for (int k = 0; k <= ROWS; k++) begin
      cycle(1'b1, 3'd5, 0, 0);
      if (busy) busy_cnt++;
      if (k >= 1 && k <= ROWS) check("fill_row_lit", 32'(grid_ram[(k-1)*COLS]), 32'd1);
    end
    check("fill_busy_cycles", 32'(busy_cnt), 32'(ROWS));
    check("fill_ready_back", 32'(cmd_ready), 32'd1);
    check("fill_all_ones", 32'(&grid_ram), 32'd1);
    cycle(1'b0, 3'd0, 0, 0);

    // FILL_ROW 2 then INVERT_ALL.
    do_reset();
    cycle(1'b1, 3'd6, 0, 2);
    cycle(1'b1, 3'd7, 0, 0);
    repeat (ROWS) cycle(1'b0, 3'd0, 0, 0);
    bad = 0;
    for (int i = 0; i < CELLS; i++) begin
      if (grid_ram[i] !== ((i >= 80 && i < 120) ? 1'b0 : 1'b1)) bad++;
    end
    check("invert_pattern_bad_bits", 32'(bad), 32'd0);
    check("invert_done_busy", 32'(busy), 32'd0);

    // Reset in the middle of a FILL_ALL sweep (SWEEP cycle 12).
    do_reset();
    cycle(1'b1, 3'd5, 0, 0);
    repeat (11) cycle(1'b0, 3'd0, 0, 0);
    check("midsweep_busy", 32'(busy), 32'd1);
    check("midsweep_row10", 32'(grid_ram[10*COLS + 5]), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_grid_any", 32'(|grid_ram), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk_74a);
    #1;
    reset = 1'b0;
    model_reset();
    cycle(1'b0, 3'd0, 0, 0);
    check("abort_ready_after", 32'(cmd_ready), 32'd1);

    // Random traffic; whole-grid ops are thinned so cell ops dominate.
    for (int n = 0; n < 400; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if ((op == 3'd4 || op == 3'd5 || op == 3'd7) && ($urandom_range(0, 5) != 0)) op = 3'd3;
      cycle(($urandom_range(0, 9) < 7), op, int'($urandom_range(0, 45)),
            int'($urandom_range(0, 31)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
